clahe_cdf_lut_builder: RTL and testbench

Per-tile engine that sits between a tile's histogram RAM and its CDF LUT RAM, both instances of the simple dual-port RAM with a registered read port. On `start` it reads all histogram bins through the histogram RAM's read port in two passes. The first pass measures the clipped excess. The second pass applies clipping, redistributes the excess, accumulates the CDF and writes the scaled mapping into the LUT RAM's write port. It can also zero the histogram RAM for the next frame.

---
 rtl/clahe_cdf_lut_builder.sv | 164 ++++++++++++++++
 tb/tb_clahe_cdf_lut_builder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clahe_cdf_lut_builder.sv
// Per-tile CLAHE engine: scans a tile histogram twice (excess measurement, then
// clip/redistribute/CDF accumulation) and writes the scaled mapping into a LUT RAM.
module clahe_cdf_lut_builder #(
    parameter int HIST_WIDTH = 16,
    parameter int LUT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int TILE_SHIFT = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [HIST_WIDTH-1:0] clip_limit,
    input  logic                  clear_hist,
    output logic [ADDR_WIDTH-1:0] hist_rd_addr,
    input  logic [HIST_WIDTH-1:0] hist_rd_data,
    output logic                  hist_we,
    output logic [ADDR_WIDTH-1:0] hist_waddr,
    output logic [HIST_WIDTH-1:0] hist_wdata,
    output logic                  lut_we,
    output logic [ADDR_WIDTH-1:0] lut_waddr,
    output logic [LUT_WIDTH-1:0]  lut_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int CDF_W   = HIST_WIDTH + ADDR_WIDTH;
    localparam int PROD_W  = CDF_W + LUT_WIDTH;
    localparam int LUT_MAX = (1 << LUT_WIDTH) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_CALC,
        S_P2,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [HIST_WIDTH-1:0] r_clipLimit;
    logic                  r_clearHist;
    logic [CDF_W-1:0]      r_excess;
    logic [HIST_WIDTH-1:0] r_inc;
    logic [CDF_W-1:0]      r_cdf;
    logic                  r_addrValid;
    logic                  r_dataValid;
    logic [ADDR_WIDTH-1:0] r_dataAddr;

    logic                  w_over;
    logic [HIST_WIDTH-1:0] w_excessAdd;
    logic [HIST_WIDTH-1:0] w_kept;
    logic [HIST_WIDTH:0]   w_clipped;
    logic [CDF_W-1:0]      w_cdfNext;
    logic [PROD_W-1:0]     w_product;
    logic [PROD_W-1:0]     w_scaled;
    logic [LUT_WIDTH-1:0]  w_lut;

    // A clip limit of zero disables clipping entirely.
    assign w_over      = (r_clipLimit != '0) && (hist_rd_data > r_clipLimit);
    assign w_excessAdd = w_over ? (hist_rd_data - r_clipLimit) : '0;
    assign w_kept      = w_over ? r_clipLimit : hist_rd_data;
    assign w_clipped   = {1'b0, w_kept} + {1'b0, r_inc};
    assign w_cdfNext   = r_cdf + CDF_W'(w_clipped);
    assign w_product   = PROD_W'(w_cdfNext) * PROD_W'(LUT_MAX);
    assign w_scaled    = w_product >> TILE_SHIFT;
    assign w_lut       = (w_scaled > PROD_W'(LUT_MAX)) ? LUT_WIDTH'(LUT_MAX)
                                                       : w_scaled[LUT_WIDTH-1:0];

    assign hist_wdata  = '0;

    // Read pipeline: an address issued in one cycle returns data in the next, so
    // r_dataValid/r_dataAddr track the bin currently on hist_rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clipLimit  <= '0;
            r_clearHist  <= 1'b0;
            r_excess     <= '0;
            r_inc        <= '0;
            r_cdf        <= '0;
            r_addrValid  <= 1'b0;
            r_dataValid  <= 1'b0;
            r_dataAddr   <= '0;
            hist_rd_addr <= '0;
            hist_we      <= 1'b0;
            hist_waddr   <= '0;
            lut_we       <= 1'b0;
            lut_waddr    <= '0;
            lut_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            hist_we     <= 1'b0;
            lut_we      <= 1'b0;
            done        <= 1'b0;
            r_dataValid <= r_addrValid;

            if (r_addrValid) begin
                r_dataAddr <= hist_rd_addr;
                if (hist_rd_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                    r_addrValid <= 1'b0;
                end else begin
                    hist_rd_addr <= hist_rd_addr + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_clipLimit  <= clip_limit;
                        r_clearHist  <= clear_hist;
                        r_excess     <= '0;
                        r_cdf        <= '0;
                        hist_rd_addr <= '0;
                        r_addrValid  <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= S_P1;
                    end
                end
                S_P1: begin
                    if (r_dataValid) begin
                        r_excess <= r_excess + CDF_W'(w_excessAdd);
                    end
                    if (r_dataValid && !r_addrValid) begin
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // The residual excess below one per bin is intentionally dropped.
                    r_inc        <= r_excess[CDF_W-1:ADDR_WIDTH];
                    hist_rd_addr <= '0;
                    r_addrValid  <= 1'b1;
                    r_state      <= S_P2;
                end
                S_P2: begin
                    // Clear a bin while its data is on the bus; the read port has
                    // already moved on, so the addresses never collide.
                    if (r_addrValid) begin
                        hist_we    <= r_clearHist;
                        hist_waddr <= hist_rd_addr;
                    end
                    if (r_dataValid) begin
                        r_cdf     <= w_cdfNext;
                        lut_we    <= 1'b1;
                        lut_waddr <= r_dataAddr;
                        lut_wdata <= w_lut;
                    end
                    if (!r_addrValid && !r_dataValid && lut_we) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_cdf_lut_builder.sv
// Directed bench for clahe_cdf_lut_builder with behavioural histogram and LUT RAMs.
module tb_clahe_cdf_lut_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] clip_limit = '0;
    logic        clear_hist = 1'b0;
    logic [7:0]  hist_rd_addr;
    logic [15:0] hist_rd_data;
    logic        hist_we;
    logic [7:0]  hist_waddr;
    logic [15:0] hist_wdata;
    logic        lut_we;
    logic [7:0]  lut_waddr;
    logic [7:0]  lut_wdata;
    logic        busy;
    logic        done;

    logic [15:0] histMem [256];
    logic [7:0]  lutMem [256];
    logic [15:0] refHist [256];
    logic [7:0]  expLut [256];

    logic        tbLoadWe = 1'b0;
    logic [7:0]  tbLoadAddr = '0;
    logic [15:0] tbLoadData = '0;

    int checkCount = 0;
    int errCount = 0;
    int lutWrites = 0;
    int lutOrderErr = 0;
    int histWrites = 0;
    int doneCount = 0;
    int overlapErr = 0;
    logic       lutPrevWe = 1'b0;
    logic [7:0] lutPrevAddr = '0;

    clahe_cdf_lut_builder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clip_limit   (clip_limit),
        .clear_hist   (clear_hist),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
        .hist_we      (hist_we),
        .hist_waddr   (hist_waddr),
        .hist_wdata   (hist_wdata),
        .lut_we       (lut_we),
        .lut_waddr    (lut_waddr),
        .lut_wdata    (lut_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Histogram RAM with registered read, plus a bench-side loading port.
    always @(posedge clk) begin
        hist_rd_data <= histMem[hist_rd_addr];
        if (tbLoadWe) histMem[tbLoadAddr] <= tbLoadData;
        else if (hist_we) histMem[hist_waddr] <= hist_wdata;
    end

    always @(posedge clk) begin
        if (lut_we) lutMem[lut_waddr] <= lut_wdata;
    end

    // Write bursts must start at 0 and climb by one each cycle.
    always @(negedge clk) begin
        if (lut_we) begin
            if (lutPrevWe ? (lut_waddr != lutPrevAddr + 8'd1) : (lut_waddr != 8'd0))
                lutOrderErr++;
            lutWrites++;
        end
        lutPrevWe = lut_we;
        lutPrevAddr = lut_waddr;
        if (hist_we) histWrites++;
        if (done) doneCount++;
        if (busy && done) overlapErr++;
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic fillRef(input int mode);
        for (int k = 0; k < 256; k++) begin
            case (mode)
                0: refHist[k] = 16'd16;
                1: refHist[k] = (k == 100) ? 16'd4096 : 16'd0;
                2: refHist[k] = 16'd100;
                3: refHist[k] = 16'($urandom_range(0, 40));
                default: refHist[k] = 16'((k % 32) * 3);
            endcase
        end
    endtask

    task automatic loadHist();
        for (int k = 0; k < 256; k++) begin
            tbLoadAddr = 8'(k);
            tbLoadData = refHist[k];
            tbLoadWe = 1'b1;
            @(posedge clk); #1;
        end
        tbLoadWe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic buildModel(input logic [15:0] clip);
        longint excess = 0;
        longint inc;
        longint cdf = 0;
        longint kept;
        longint v;
        for (int k = 0; k < 256; k++)
            if (clip != 0 && refHist[k] > clip) excess += longint'(refHist[k]) - longint'(clip);
        inc = excess / 256;
        for (int k = 0; k < 256; k++) begin
            kept = (clip != 0 && refHist[k] > clip) ? longint'(clip) : longint'(refHist[k]);
            cdf += kept + inc;
            v = (cdf * 255) / 4096;
            expLut[k] = (v > 255) ? 8'd255 : 8'(v);
        end
    endtask

    task automatic compareLut(input string tag);
        int bad = 0;
        for (int k = 0; k < 256; k++)
            if (lutMem[k] !== expLut[k]) bad++;
        checkOutput(tag, bad, 0);
    endtask

    task automatic checkOutputsZero(input string tag);
        checkOutput(tag, longint'({hist_rd_addr, hist_we, hist_waddr, hist_wdata, lut_we,
                                   lut_waddr, lut_wdata, busy, done}), 0);
    endtask

    // Drives start in cycle 0 and optional extra pulses / reset, tracking cycles
    // from the start edge until done (or the reset abort).
    task automatic applyStimulus(input logic [15:0] clip, input logic clr, input int pulseA,
                                 input int pulseB, input int rstAt, output int doneCyc,
                                 output int busyErr);
        clip_limit = clip;
        clear_hist = clr;
        start = 1'b1;
        doneCyc = -1;
        busyErr = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            if (done) begin
                doneCyc = cyc;
                break;
            end
            if (busy !== (cyc <= 516)) busyErr++;
            start = (cyc == pulseA || cyc == pulseB);
            rst = (cyc == rstAt);
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == rstAt) begin
                checkOutputsZero("rstMidZero");
                rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] clip, input logic clr,
                               input int pulseA, input int pulseB);
        int lw0, lo0, hw0, dc0, doneCyc, busyErr;
        lw0 = lutWrites; lo0 = lutOrderErr; hw0 = histWrites; dc0 = doneCount;
        applyStimulus(clip, clr, pulseA, pulseB, -1, doneCyc, busyErr);
        checkOutput({tag, ".doneCycle"}, doneCyc, 517);
        checkOutput({tag, ".busyProfile"}, busyErr, 0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput({tag, ".busyAfter"}, longint'(busy), 0);
        checkOutput({tag, ".doneCount"}, doneCount - dc0, 1);
        checkOutput({tag, ".lutWrites"}, lutWrites - lw0, 256);
        checkOutput({tag, ".lutOrder"}, lutOrderErr - lo0, 0);
        checkOutput({tag, ".histWrites"}, histWrites - hw0, clr ? 256 : 0);
        buildModel(clip);
        compareLut({tag, ".lutModel"});
    endtask

    initial begin
        int nonZero, lw0, doneCyc, busyErr;

        repeat (3) @(posedge clk);
        #1;
        checkOutputsZero("resetOutputs");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] uniform histogram of 16, no clipping");
        fillRef(0); loadHist();
        runAndCheck("uniform16", 16'd0, 1'b0, -1, -1);
        checkOutput("uniform16.lut0", longint'(lutMem[0]), 0);
        checkOutput("uniform16.lut127", longint'(lutMem[127]), 127);
        checkOutput("uniform16.lut255", longint'(lutMem[255]), 255);

        $display("[TB] single spike with clip 40");
        fillRef(1); loadHist();
        runAndCheck("spike", 16'd40, 1'b0, -1, -1);
        checkOutput("spike.lut0", longint'(lutMem[0]), 0);
        checkOutput("spike.lut99", longint'(lutMem[99]), 93);
        checkOutput("spike.lut100", longint'(lutMem[100]), 96);
        checkOutput("spike.lut255", longint'(lutMem[255]), 241);

        $display("[TB] uniform histogram of 100, saturating mapping");
        fillRef(2); loadHist();
        runAndCheck("uniform100", 16'd0, 1'b0, -1, -1);
        checkOutput("uniform100.lut0", longint'(lutMem[0]), 6);
        checkOutput("uniform100.lut39", longint'(lutMem[39]), 249);
        checkOutput("uniform100.lut40", longint'(lutMem[40]), 255);
        checkOutput("uniform100.lut255", longint'(lutMem[255]), 255);

        $display("[TB] random histogram with clearing, clip 20");
        fillRef(3); loadHist();
        runAndCheck("randomClear", 16'd20, 1'b1, -1, -1);
        nonZero = 0;
        for (int k = 0; k < 256; k++) if (histMem[k] !== 16'd0) nonZero++;
        checkOutput("randomClear.histZeroed", nonZero, 0);

        $display("[TB] reset in the middle of a run");
        fillRef(0); loadHist();
        applyStimulus(16'd0, 1'b0, -1, -1, 300, doneCyc, busyErr);
        checkOutput("rstMid.busyProfile", busyErr, 0);
        lw0 = lutWrites;
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("rstMid.noWrites", lutWrites - lw0, 0);
        checkOutput("rstMid.idleBusy", longint'(busy), 0);
        fillRef(4); loadHist();
        runAndCheck("afterRst", 16'd0, 1'b0, -1, -1);

        $display("[TB] extra start pulses while busy");
        fillRef(4); loadHist();
        runAndCheck("doubleStart", 16'd50, 1'b0, 10, 516);

        checkOutput("busyDoneOverlap", overlapErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
